// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX pipeline register sitting directly in front of the ALU. Captures the
//   decoded operands and control every cycle, forwards EX/MEM and MEM/WB
//   results into the ALU operands, and holds decode (with a bubble into EX)
//   when the instruction in EX is a load that the decoding instruction reads.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill the instruction entering ID/EX
//   id_*                     decoded instruction fields from decode
//   mem_reg_write/rd/result  EX/MEM writeback candidate for forwarding
//   wb_reg_write/rd/result   MEM/WB writeback candidate for forwarding
//   stall                    combinational decode/fetch hold
//   ex_valid, alu_ctl        registered valid and ALU op
//   a_in, b_in               forwarded ALU operands
//   ex_store_data            forwarded rt value for stores
//   ex_rd, ex_reg_write,
//   ex_mem_read, ex_mem_write  registered destination and control
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [4:0]         id_alu_ctl,
    input  logic [WIDTH-1:0]   id_rs_val,
    input  logic [WIDTH-1:0]   id_rt_val,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_alu_src,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [WIDTH-1:0]   mem_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]   wb_result,
    output logic               stall,
    output logic               ex_valid,
    output logic [4:0]         alu_ctl,
    output logic [WIDTH-1:0]   a_in,
    output logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   ex_store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);

    logic               vld_p1;
    logic [4:0]         alu_ctl_p1;
    logic [RADDR_W-1:0] rs_p1;
    logic [RADDR_W-1:0] rt_p1;
    logic [RADDR_W-1:0] rd_p1;
    logic [WIDTH-1:0]   rs_val_p1;
    logic [WIDTH-1:0]   rt_val_p1;
    logic [WIDTH-1:0]   imm_p1;
    logic               alu_src_p1;
    logic               reg_write_p1;
    logic               mem_read_p1;
    logic               mem_write_p1;
    logic [WIDTH-1:0]   fwd_rt;

    // Operand select: EX/MEM has the younger value so it wins over MEM/WB.
    // Index 0 is never forwarded; the register-file value (0) is used instead.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [RADDR_W-1:0] idx,
        input logic [WIDTH-1:0]   reg_val,
        input logic               m_we,
        input logic [RADDR_W-1:0] m_rd,
        input logic [WIDTH-1:0]   m_val,
        input logic               w_we,
        input logic [RADDR_W-1:0] w_rd,
        input logic [WIDTH-1:0]   w_val
    );
        if (m_we && (m_rd != '0) && (m_rd == idx))
            return m_val;
        else if (w_we && (w_rd != '0) && (w_rd == idx))
            return w_val;
        else
            return reg_val;
    endfunction

    // Load-use hazard: the load in EX has no result yet, so decode must wait.
    assign stall = id_valid & vld_p1 & mem_read_p1 & (rd_p1 != '0) &
                   ((rd_p1 == id_rs) | (rd_p1 == id_rt));

    // ---- ID -> EX boundary (p1) ----
    // A bubble clears every field so its indices are 0 and it cannot forward
    // or trigger a stall.
    always_ff @(posedge clk) begin
        if (rst || flush || stall) begin
            vld_p1       <= 1'b0;
            alu_ctl_p1   <= '0;
            rs_p1        <= '0;
            rt_p1        <= '0;
            rd_p1        <= '0;
            rs_val_p1    <= '0;
            rt_val_p1    <= '0;
            imm_p1       <= '0;
            alu_src_p1   <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
        end else begin
            vld_p1       <= id_valid;
            alu_ctl_p1   <= id_alu_ctl;
            rs_p1        <= id_rs;
            rt_p1        <= id_rt;
            rd_p1        <= id_rd;
            rs_val_p1    <= id_rs_val;
            rt_val_p1    <= id_rt_val;
            imm_p1       <= id_imm;
            alu_src_p1   <= id_alu_src;
            reg_write_p1 <= id_reg_write;
            mem_read_p1  <= id_mem_read;
            mem_write_p1 <= id_mem_write;
        end
    end

    // ---- EX operand forwarding (combinational on p1 indices) ----
    assign a_in   = fwd_sel(rs_p1, rs_val_p1, mem_reg_write, mem_rd, mem_result,
                            wb_reg_write, wb_rd, wb_result);
    assign fwd_rt = fwd_sel(rt_p1, rt_val_p1, mem_reg_write, mem_rd, mem_result,
                            wb_reg_write, wb_rd, wb_result);

    assign b_in          = alu_src_p1 ? imm_p1 : fwd_rt;
    assign ex_store_data = fwd_rt;

    assign ex_valid     = vld_p1;
    assign alu_ctl      = alu_ctl_p1;
    assign ex_rd        = rd_p1;
    // Control is gated so an invalid slot can never write or touch memory.
    assign ex_reg_write = vld_p1 & reg_write_p1;
    assign ex_mem_read  = vld_p1 & mem_read_p1;
    assign ex_mem_write = vld_p1 & mem_write_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int WIDTH   = 32;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               rst, flush, id_valid;
    logic [4:0]         id_alu_ctl;
    logic [WIDTH-1:0]   id_rs_val, id_rt_val, id_imm;
    logic [RADDR_W-1:0] id_rs, id_rt, id_rd;
    logic               id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic               mem_reg_write, wb_reg_write;
    logic [RADDR_W-1:0] mem_rd, wb_rd;
    logic [WIDTH-1:0]   mem_result, wb_result;
    logic               stall, ex_valid;
    logic [4:0]         alu_ctl;
    logic [WIDTH-1:0]   a_in, b_in, ex_store_data;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_reg_write, ex_mem_read, ex_mem_write;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_alu_ctl(id_alu_ctl), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .alu_ctl(alu_ctl),
        .a_in(a_in), .b_in(b_in), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    // Reference: the instruction currently occupying EX, as a plain record.
    typedef struct packed {
        bit                v;
        bit [4:0]          ctl;
        bit [RADDR_W-1:0]  rs, rt, rd;
        bit [WIDTH-1:0]    rsv, rtv, imm;
        bit                src, rw, mr, mw;
    } ex_t;

    ex_t m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [WIDTH-1:0] model_operand(input bit [RADDR_W-1:0] idx,
                                                     input bit [WIDTH-1:0] regv);
        if (idx == 0) return regv;
        if (mem_reg_write && mem_rd == idx) return mem_result;
        if (wb_reg_write && wb_rd == idx) return wb_result;
        return regv;
    endfunction

    function automatic bit model_stall();
        return id_valid && m.v && m.mr && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt);
    endfunction

    task automatic compare_model();
        bit [WIDTH-1:0] rt_op;
        rt_op = model_operand(m.rt, m.rtv);
        chk("stall",         32'(stall),         32'(model_stall()));
        chk("ex_valid",      32'(ex_valid),      32'(m.v));
        chk("alu_ctl",       32'(alu_ctl),       32'(m.ctl));
        chk("ex_rd",         32'(ex_rd),         32'(m.rd));
        chk("a_in",          a_in,               model_operand(m.rs, m.rsv));
        chk("b_in",          b_in,               m.src ? m.imm : rt_op);
        chk("ex_store_data", ex_store_data,      rt_op);
        chk("ex_reg_write",  32'(ex_reg_write),  32'(m.v & m.rw));
        chk("ex_mem_read",   32'(ex_mem_read),   32'(m.v & m.mr));
        chk("ex_mem_write",  32'(ex_mem_write),  32'(m.v & m.mw));
    endtask

    // Called just after the rising edge, inputs still as they were at the edge.
    task automatic model_edge(input bit stall_now);
        if (rst || flush || stall_now) begin
            m = '0;
        end else begin
            m.v = id_valid;   m.ctl = id_alu_ctl;
            m.rs = id_rs;     m.rt = id_rt;     m.rd = id_rd;
            m.rsv = id_rs_val; m.rtv = id_rt_val; m.imm = id_imm;
            m.src = id_alu_src; m.rw = id_reg_write;
            m.mr = id_mem_read; m.mw = id_mem_write;
        end
    endtask

    // Compare before the edge, advance the model across it, land on negedge.
    task automatic step();
        bit s;
        #1;
        compare_model();
        s = model_stall();
        @(posedge clk);
        model_edge(s);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; flush = 0; id_valid = 0; id_alu_ctl = 0;
        id_rs_val = 0; id_rt_val = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    initial begin
        bit s;
        logic [4:0] ops [7];
        ops = '{5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9};

        // 1: reset held two cycles with a valid instruction at decode
        clear_inputs();
        rst = 1; id_valid = 1; id_alu_ctl = 5'd2; id_rs = 3; id_rs_val = 32'h55;
        @(posedge clk);
        model_edge(1'b0);
        @(negedge clk);
        step();
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_alu_ctl",  32'(alu_ctl),  32'd0);
        chk("rst_a_in",     a_in,          32'd0);
        chk("rst_b_in",     b_in,          32'd0);
        chk("rst_stall",    32'(stall),    32'd0);

        // 2: add r5 = r3 + r4
        clear_inputs();
        id_valid = 1; id_alu_ctl = 5'd2; id_rs = 3; id_rs_val = 5;
        id_rt = 4; id_rt_val = 7; id_rd = 5; id_reg_write = 1;
        step();
        #1;
        chk("add_alu_ctl",  32'(alu_ctl),  32'd2);
        chk("add_a_in",     a_in,          32'd5);
        chk("add_b_in",     b_in,          32'd7);
        chk("add_ex_rd",    32'(ex_rd),    32'd5);
        chk("add_ex_valid", 32'(ex_valid), 32'd1);

        // 3: forwarding priority on rs=5
        id_rs = 5; id_rs_val = 32'h99;
        step();
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'h10;
        wb_reg_write = 1;  wb_rd = 5;  wb_result = 32'h20;
        #1;
        chk("fwd_mem_wins", a_in, 32'h10);
        mem_reg_write = 0;
        #1;
        chk("fwd_wb", a_in, 32'h20);
        wb_reg_write = 0;
        #1;
        chk("fwd_none", a_in, 32'h99);

        // 4: load-use stall and bubble
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 8; id_alu_ctl = 5'd2;
        step();
        id_mem_read = 0; id_rd = 9; id_rs = 8; id_rt = 2;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        step();
        #1;
        chk("lu_bubble_valid", 32'(ex_valid),    32'd0);
        chk("lu_bubble_mr",    32'(ex_mem_read), 32'd0);
        chk("lu_stall_drop",   32'(stall),       32'd0);

        // 5: r0 never forwarded; immediate select
        clear_inputs();
        id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 0;
        id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
        step();
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'hFF;
        #1;
        chk("r0_a_in",  a_in, 32'd0);
        chk("imm_b_in", b_in, 32'hFFFF_FFFC);

        // 6: flush during a stall
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 9;
        step();
        id_mem_read = 0; id_rs = 9; id_rd = 3; id_mem_write = 1; flush = 1;
        #1;
        chk("fl_stall", 32'(stall), 32'd1);
        step();
        #1;
        chk("fl_ex_valid",     32'(ex_valid),     32'd0);
        chk("fl_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("fl_ex_mem_write", 32'(ex_mem_write), 32'd0);
        flush = 0;

        // Randomized traffic with small index range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 11) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_alu_ctl    = ops[$urandom_range(0, 6)];
            id_rs         = RADDR_W'($urandom_range(0, 7));
            id_rt         = RADDR_W'($urandom_range(0, 7));
            id_rd         = RADDR_W'($urandom_range(0, 7));
            id_rs_val     = (id_rs == 0) ? 32'd0 : $urandom;
            id_rt_val     = (id_rt == 0) ? 32'd0 : $urandom;
            id_imm        = $urandom;
            id_alu_src    = 1'($urandom_range(0, 1));
            id_reg_write  = 1'($urandom_range(0, 1));
            id_mem_read   = ($urandom_range(0, 2) == 0);
            id_mem_write  = ($urandom_range(0, 3) == 0);
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_rd        = RADDR_W'($urandom_range(0, 7));
            mem_result    = $urandom;
            wb_reg_write  = 1'($urandom_range(0, 1));
            wb_rd         = RADDR_W'($urandom_range(0, 7));
            wb_result     = $urandom;
            step();
        end
        #1;
        compare_model();
        s = model_stall();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
